// File: rtl/vesa_mode_ctrl.sv
// Run-time mode controller for the VESA timing generator: accepts mode requests,
// waits for frame end, blanks the timing core while reloading parameters, then settles.
module vesa_mode_ctrl #(
  parameter int DEFAULT_MODE  = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  input  logic        frame_end,
  output logic        mode_ack,
  output logic        mode_err,
  output logic        busy,
  output logic [1:0]  cur_mode,
  output logic        tg_en,
  output logic [11:0] h_active,
  output logic [11:0] h_fp,
  output logic [11:0] h_sync,
  output logic [11:0] h_bp,
  output logic [11:0] h_total,
  output logic [10:0] v_active,
  output logic [10:0] v_fp,
  output logic [10:0] v_sync,
  output logic [10:0] v_bp,
  output logic [10:0] v_total
);

  localparam int ROW_W = 5 * 12 + 5 * 11;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_BLANK      = 2'd2;
  localparam logic [1:0] ST_SETTLE     = 2'd3;

  localparam logic [1:0] MODE_INVALID  = 2'd3;
  localparam logic [7:0] SETTLE_LAST   = 8'(SETTLE_CYCLES - 1);

  // Row layout: H active/fp/sync/bp/total, then V active/fp/sync/bp/total.
  // Totals are precomputed so no adder sits in the datapath.
  function automatic logic [ROW_W-1:0] mode_row(input logic [1:0] m);
    case (m)
      2'd0:    mode_row = {12'd640,  12'd16,  12'd96, 12'd48,  12'd800,
                           11'd480,  11'd10,  11'd2,  11'd33,  11'd525};
      2'd1:    mode_row = {12'd1280, 12'd110, 12'd40, 12'd220, 12'd1650,
                           11'd720,  11'd5,   11'd5,  11'd20,  11'd750};
      2'd2:    mode_row = {12'd1920, 12'd128, 12'd24, 12'd128, 12'd2200,
                           11'd1080, 11'd3,   11'd4,  11'd33,  11'd1120};
      default: mode_row = '0;
    endcase
  endfunction

  logic [ROW_W-1:0] mode_rom [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rom
      assign mode_rom[gi] = mode_row(2'(gi));
    end
  endgenerate

  logic [1:0]       state_reg,      state_next;
  logic [1:0]       pend_mode_reg,  pend_mode_next;
  logic [7:0]       settle_cnt_reg, settle_cnt_next;
  logic [ROW_W-1:0] param_reg,      param_next;
  logic [1:0]       cur_mode_reg,   cur_mode_next;
  logic             tg_en_reg,      tg_en_next;
  logic             busy_reg,       busy_next;
  logic             ack_reg,        ack_next;
  logic             err_reg,        err_next;

  always_comb begin
    state_next      = state_reg;
    pend_mode_next  = pend_mode_reg;
    settle_cnt_next = settle_cnt_reg;
    param_next      = param_reg;
    cur_mode_next   = cur_mode_reg;
    tg_en_next      = tg_en_reg;
    busy_next       = busy_reg;
    ack_next        = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy_next  = 1'b0;
        tg_en_next = 1'b1;
        if (mode_req) begin
          if (mode_sel == MODE_INVALID) begin
            err_next = 1'b1;
          end else if (mode_sel == cur_mode_reg) begin
            ack_next = 1'b1;
          end else begin
            pend_mode_next = mode_sel;
            busy_next      = 1'b1;
            state_next     = ST_WAIT_FRAME;
          end
        end
      end

      // Only reachable one cycle after acceptance, so a frame_end coincident
      // with the request is never used.
      ST_WAIT_FRAME: begin
        if (frame_end) begin
          tg_en_next = 1'b0;
          state_next = ST_BLANK;
        end
      end

      ST_BLANK: begin
        param_next      = mode_rom[pend_mode_reg];
        cur_mode_next   = pend_mode_reg;
        settle_cnt_next = 8'd0;
        state_next      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          tg_en_next = 1'b1;
          ack_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          settle_cnt_next = settle_cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pend_mode_reg  <= 2'(DEFAULT_MODE);
      settle_cnt_reg <= 8'd0;
      param_reg      <= mode_row(2'(DEFAULT_MODE));
      cur_mode_reg   <= 2'(DEFAULT_MODE);
      tg_en_reg      <= 1'b1;
      busy_reg       <= 1'b0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_mode_reg  <= pend_mode_next;
      settle_cnt_reg <= settle_cnt_next;
      param_reg      <= param_next;
      cur_mode_reg   <= cur_mode_next;
      tg_en_reg      <= tg_en_next;
      busy_reg       <= busy_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
    end
  end

  assign {h_active, h_fp, h_sync, h_bp, h_total,
          v_active, v_fp, v_sync, v_bp, v_total} = param_reg;

  assign cur_mode = cur_mode_reg;
  assign tg_en    = tg_en_reg;
  assign busy     = busy_reg;
  assign mode_ack = ack_reg;
  assign mode_err = err_reg;

endmodule

// File: tb/tb_vesa_mode_ctrl.sv
// Directed plus randomized bench for vesa_mode_ctrl, checked against a
// transaction-timeline model of the mode switch.
module tb_vesa_mode_ctrl;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        frame_end;
  logic        mode_ack, mode_err, busy, tg_en;
  logic [1:0]  cur_mode;
  logic [11:0] h_active, h_fp, h_sync, h_bp, h_total;
  logic [10:0] v_active, v_fp, v_sync, v_bp, v_total;

  vesa_mode_ctrl #(.DEFAULT_MODE(2), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .mode_sel(mode_sel),
    .frame_end(frame_end), .mode_ack(mode_ack), .mode_err(mode_err),
    .busy(busy), .cur_mode(cur_mode), .tg_en(tg_en),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp), .h_total(h_total),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp), .v_total(v_total)
  );

  always #5 clk = ~clk;

  // Mode table fields; totals are derived here as plain sums.
  int hf [3][4] = '{'{640, 16, 96, 48}, '{1280, 110, 40, 220}, '{1920, 128, 24, 128}};
  int vf [3][4] = '{'{480, 10, 2, 33},  '{720, 5, 5, 20},      '{1080, 3, 4, 33}};

  int n_assert = 0;
  int n_fail   = 0;

  // Timeline model: one outstanding switch, described by its acceptance and
  // frame_end cycles; every expected output follows from those two numbers.
  int k;
  bit txn_active;
  int acc, fe, tmode, cur_m, ack_at, err_at;

  function automatic int htot(input int m);
    return hf[m][0] + hf[m][1] + hf[m][2] + hf[m][3];
  endfunction

  function automatic int vtot(input int m);
    return vf[m][0] + vf[m][1] + vf[m][2] + vf[m][3];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    txn_active = 0;
    cur_m      = 2;
    ack_at     = -1;
    err_at     = -1;
    fe         = -1;
  endtask

  task automatic check_outputs();
    bit exp_busy, exp_tg;
    int pm;
    exp_busy = txn_active && (k > acc);
    exp_tg   = !(txn_active && fe >= 0 && k >= fe + 1 && k <= fe + 1 + S);
    pm       = (txn_active && fe >= 0 && k >= fe + 2) ? tmode : cur_m;
    chk("mode_ack", int'(mode_ack), int'(k == ack_at));
    chk("mode_err", int'(mode_err), int'(k == err_at));
    chk("busy",     int'(busy),     int'(exp_busy));
    chk("tg_en",    int'(tg_en),    int'(exp_tg));
    chk("cur_mode", int'(cur_mode), pm);
    chk("h_active", int'(h_active), hf[pm][0]);
    chk("h_sync",   int'(h_sync),   hf[pm][2]);
    chk("h_total",  int'(h_total),  htot(pm));
    chk("v_active", int'(v_active), vf[pm][0]);
    chk("v_bp",     int'(v_bp),     vf[pm][3]);
    chk("v_total",  int'(v_total),  vtot(pm));
  endtask

  task automatic model_inputs(input bit r, input int s, input bit f);
    if (!rst_n) return;
    if (!txn_active) begin
      if (r) begin
        if (s == 3)          err_at = k + 1;
        else if (s == cur_m) ack_at = k + 1;
        else begin
          txn_active = 1;
          acc        = k;
          tmode      = s;
          fe         = -1;
        end
      end
    end else if (fe < 0 && f && k > acc) begin
      fe     = k;
      ack_at = k + 2 + S;
    end
  endtask

  task automatic cyc(input bit r, input int s, input bit f);
    logic [1:0] sel;
    @(posedge clk);
    k++;
    if (txn_active && fe >= 0 && k == fe + 2 + S) begin
      cur_m      = tmode;
      txn_active = 0;
    end
    sel = s[1:0];
    #1;
    mode_req  = r;
    mode_sel  = sel;
    frame_end = f;
    @(negedge clk);
    check_outputs();
    model_inputs(r, s, f);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (txn_active && guard < 500) begin
      cyc(0, 0, (guard % 8) == 7);
      guard++;
    end
    n_assert++;
    assert (guard < 500) else begin
      n_fail++;
      $error("FAIL wait_idle timeout: observed %0d cycles required < 500", guard);
    end
  endtask

  task automatic switch_to(input int m);
    if (m != cur_m) begin
      cyc(1, m, 0);
      repeat (3) cyc(0, 0, 0);
      cyc(0, 0, 1);
      wait_idle();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tg_en"},    int'(tg_en),    1);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_ack"},      int'(mode_ack), 0);
    chk({tag, "_err"},      int'(mode_err), 0);
    chk({tag, "_cur_mode"}, int'(cur_mode), 2);
    chk({tag, "_h_active"}, int'(h_active), 1920);
    chk({tag, "_h_total"},  int'(h_total),  2200);
    chk({tag, "_v_active"}, int'(v_active), 1080);
    chk({tag, "_v_total"},  int'(v_total),  1120);
  endtask

  initial begin
    int n, guard, target;
    rst_n     = 1'b0;
    mode_req  = 1'b0;
    mode_sel  = 2'd0;
    frame_end = 1'b0;
    k         = 0;
    acc       = 0;
    tmode     = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (5) cyc(0, 0, 0);

    // Request mode 0, frame_end 50 cycles later
    cyc(1, 0, 0);
    n = k;
    while (k < n + 49) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (25) cyc(0, 0, 0);
    chk("mode0_cur_mode", int'(cur_mode), 0);
    chk("mode0_h_total",  int'(h_total),  800);
    chk("mode0_v_total",  int'(v_total),  525);

    // Invalid and same-mode requests
    cyc(1, 3, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);

    // frame_end coincident with acceptance, noisy requests while busy
    cyc(1, 2, 1);
    repeat (10) cyc($urandom_range(0, 1), $urandom_range(0, 3), 0);
    cyc(0, 0, 1);
    repeat (16) cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    wait_idle();
    repeat (3) cyc(0, 0, 0);

    // Back-to-back: request mode 1 in the ack cycle of the switch to mode 0
    switch_to(2);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    guard = 0;
    while (k + 1 != ack_at && guard < 100) begin
      cyc(0, 0, 0);
      guard++;
    end
    n_assert++;
    assert (guard < 100) else begin
      n_fail++;
      $error("FAIL ack_wait timeout: observed %0d cycles required < 100", guard);
    end
    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    wait_idle();
    repeat (2) cyc(0, 0, 0);
    chk("b2b_cur_mode", int'(cur_mode), 1);
    chk("b2b_h_total",  int'(h_total),  1650);
    chk("b2b_v_total",  int'(v_total),  750);

    // Random traffic
    repeat (1500)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3), $urandom_range(0, 39) == 0);
    wait_idle();

    // Reset asserted during SETTLE
    target = (cur_m == 0) ? 1 : 0;
    cyc(1, target, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (6) cyc(0, 0, 0);
    chk("pre_abort_tg_en", int'(tg_en), 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    model_reset();
    repeat (2) cyc(0, 0, 0);
    rst_n = 1'b1;
    repeat (40) cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
